// File: rtl/adc_osr_mc_if.sv
// Sample-stream and result handshake bundle for the multi-channel ADC oversampler.
// The slave side is the oversampler; the master side is the front-end plus the result consumer.
interface adc_osr_mc_if #(
    parameter int DATA_W   = 12,
    parameter int CH_W     = 2,
    parameter int MAX_MODE = 4
);
    localparam int OUT_W = DATA_W + MAX_MODE;

    logic              sample_valid_in;
    logic [CH_W-1:0]   sample_ch_in;
    logic [DATA_W-1:0] sample_data_in;
    logic              result_valid_out;
    logic              result_ready_in;
    logic [CH_W-1:0]   result_ch_out;
    logic [OUT_W-1:0]  result_data_out;

    modport slave (
        input  sample_valid_in, sample_ch_in, sample_data_in, result_ready_in,
        output result_valid_out, result_ch_out, result_data_out
    );

    modport master (
        output sample_valid_in, sample_ch_in, sample_data_in, result_ready_in,
        input  result_valid_out, result_ch_out, result_data_out
    );
endinterface

// File: rtl/adc_osr_mc.sv
// Multi-channel ADC oversampler: sums 4**m samples per channel and emits a left-aligned
// average through a 1-deep valid/ready output register with a sticky overrun flag.
module adc_osr_mc #(
    parameter int DATA_W   = 12,
    parameter int CH_N     = 4,
    parameter int CH_W     = 2,
    parameter int MAX_MODE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear_in,
    input  logic [2:0]          osr_mode_in,
    output logic                overrun_out,
    adc_osr_mc_if.slave         bus
);
    localparam int OUT_W = DATA_W + MAX_MODE;
    localparam int ACC_W = DATA_W + 2 * MAX_MODE;
    localparam int CNT_W = 2 * MAX_MODE;
    localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(CH_N);

    logic [ACC_W-1:0]  acc_q  [CH_N];
    logic [ACC_W-1:0]  acc_d  [CH_N];
    logic [CNT_W-1:0]  cnt_q  [CH_N];
    logic [CNT_W-1:0]  cnt_d  [CH_N];
    logic [2:0]        mode_q [CH_N];
    logic [2:0]        mode_d [CH_N];

    logic              res_valid_q, res_valid_d;
    logic [CH_W-1:0]   res_ch_q, res_ch_d;
    logic [OUT_W-1:0]  res_data_q, res_data_d;
    logic              overrun_q, overrun_d;

    logic              accept;
    logic [CH_W-1:0]   ch_idx;
    logic [2:0]        req_mode;
    logic [2:0]        eff_mode;
    logic              is_first;
    logic              is_last;
    logic              done;
    logic [CNT_W:0]    win;
    logic [CNT_W-1:0]  win_last;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  shifted;
    logic [OUT_W-1:0]  res_val;

    always_comb begin
        accept   = bus.sample_valid_in && ({1'b0, bus.sample_ch_in} < CH_LIM);
        // Rejected channels are steered to index 0 so no array read goes out of range.
        ch_idx   = accept ? bus.sample_ch_in : '0;
        req_mode = (osr_mode_in > 3'(MAX_MODE)) ? 3'd0 : osr_mode_in;
        is_first = (cnt_q[ch_idx] == '0);
        eff_mode = is_first ? req_mode : mode_q[ch_idx];
        win      = (CNT_W + 1)'(1) << {eff_mode, 1'b0};
        win_last = CNT_W'(win - (CNT_W + 1)'(1));
        is_last  = (cnt_q[ch_idx] == win_last);
        sum      = ACC_W'(bus.sample_data_in) + (is_first ? '0 : acc_q[ch_idx]);
        shifted  = (sum >> eff_mode) << (3'(MAX_MODE) - eff_mode);
        res_val  = shifted[OUT_W-1:0];
        done     = accept && is_last;

        acc_d       = acc_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        res_valid_d = res_valid_q;
        res_ch_d    = res_ch_q;
        res_data_d  = res_data_q;
        overrun_d   = overrun_q;

        if (clear_in) begin
            for (int i = 0; i < CH_N; i++) begin
                acc_d[i]  = '0;
                cnt_d[i]  = '0;
                mode_d[i] = '0;
            end
            res_valid_d = 1'b0;
            res_ch_d    = '0;
            res_data_d  = '0;
            overrun_d   = 1'b0;
        end else begin
            if (accept) begin
                if (is_first) begin
                    mode_d[ch_idx] = req_mode;
                end
                acc_d[ch_idx] = sum;
                cnt_d[ch_idx] = is_last ? '0 : cnt_q[ch_idx] + 1'b1;
            end
            if (done) begin
                if (!res_valid_q || bus.result_ready_in) begin
                    res_valid_d = 1'b1;
                    res_ch_d    = ch_idx;
                    res_data_d  = res_val;
                end else begin
                    overrun_d = 1'b1;
                end
            end else if (res_valid_q && bus.result_ready_in) begin
                res_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CH_N; i++) begin
                acc_q[i]  <= '0;
                cnt_q[i]  <= '0;
                mode_q[i] <= '0;
            end
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_data_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            mode_q      <= mode_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_data_q  <= res_data_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.result_valid_out = res_valid_q;
    assign bus.result_ch_out    = res_ch_q;
    assign bus.result_data_out  = res_data_q;
    assign overrun_out          = overrun_q;
endmodule

// File: tb/tb_adc_osr_mc.sv
// Bench for adc_osr_mc: per-channel sample-sum model checked every cycle, plus literal result checks.
module tb_adc_osr_mc;
    localparam int DATA_W   = 12;
    localparam int CH_N     = 3;
    localparam int CH_W     = 2;
    localparam int MAX_MODE = 4;
    localparam int OUT_W    = DATA_W + MAX_MODE;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clear;
    logic [2:0] osr_mode;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    adc_osr_mc_if #(.DATA_W(DATA_W), .CH_W(CH_W), .MAX_MODE(MAX_MODE)) bus ();

    adc_osr_mc #(.DATA_W(DATA_W), .CH_N(CH_N), .CH_W(CH_W), .MAX_MODE(MAX_MODE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_in    (clear),
        .osr_mode_in (osr_mode),
        .overrun_out (overrun),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // model state: samples seen in the current window, window mode, running sum
    int     m_cnt  [CH_N];
    int     m_mode [CH_N];
    longint m_sum  [CH_N];
    int     e_valid = 0;
    int     e_ch    = 0;
    int     e_data  = 0;
    int     e_ovr   = 0;
    int     got_ch   [$];
    int     got_data [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < CH_N; i++) begin
            m_cnt[i] = 0; m_mode[i] = 0; m_sum[i] = 0;
        end
        e_valid = 0; e_ch = 0; e_data = 0; e_ovr = 0;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                int comp, c_ch, c_data, mm, rdy;
                if (bus.result_valid_out && bus.result_ready_in) begin
                    got_ch.push_back(int'(bus.result_ch_out));
                    got_data.push_back(int'(bus.result_data_out));
                end
                rdy  = int'(bus.result_ready_in);
                comp = 0; c_ch = 0; c_data = 0;
                if (clear) begin
                    model_reset();
                end else begin
                    if (bus.sample_valid_in && int'(bus.sample_ch_in) < CH_N) begin
                        c_ch = int'(bus.sample_ch_in);
                        if (m_cnt[c_ch] == 0) begin
                            m_mode[c_ch] = (int'(osr_mode) > MAX_MODE) ? 0 : int'(osr_mode);
                            m_sum[c_ch]  = 0;
                        end
                        m_sum[c_ch] += longint'(bus.sample_data_in);
                        m_cnt[c_ch]++;
                        if (m_cnt[c_ch] == 4 ** m_mode[c_ch]) begin
                            mm     = m_mode[c_ch];
                            c_data = int'(m_sum[c_ch] / (64'd1 << mm)) * (1 << (MAX_MODE - mm));
                            comp   = 1;
                            m_cnt[c_ch] = 0;
                        end
                    end
                    if (comp != 0) begin
                        if (e_valid == 0 || rdy != 0) begin
                            e_valid = 1; e_ch = c_ch; e_data = c_data;
                        end else begin
                            e_ovr = 1;
                        end
                    end else if (e_valid != 0 && rdy != 0) begin
                        e_valid = 0;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1) begin
                chk("valid", 32'(bus.result_valid_out), 32'(e_valid));
                chk("ch",    32'(bus.result_ch_out),    32'(e_ch));
                chk("data",  32'(bus.result_data_out),  32'(e_data));
                chk("overrun", 32'(overrun),            32'(e_ovr));
            end
        end
    end

    task automatic send(input int ch, input int data, input int mode);
        bus.sample_valid_in = 1'b1;
        bus.sample_ch_in    = CH_W'(ch);
        bus.sample_data_in  = DATA_W'(data);
        osr_mode            = 3'(mode);
        @(negedge clk);
        bus.sample_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pop(input string name, input int ch, input int data);
        total++;
        if (got_data.size() == 0) begin
            bad++;
            $display("FAIL %s actual=no_result required=ch%0d/%h", name, ch, data);
        end else begin
            int gc, gd;
            gc = got_ch.pop_front();
            gd = got_data.pop_front();
            if (gc != ch || gd != data) begin
                bad++;
                $display("FAIL %s actual=ch%0d/%h required=ch%0d/%h", name, gc, gd, ch, data);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        osr_mode = 3'd0;
        bus.sample_valid_in = 1'b0;
        bus.sample_ch_in    = '0;
        bus.sample_data_in  = '0;
        bus.result_ready_in = 1'b1;
        #1;
        chk("rst_valid", 32'(bus.result_valid_out), 32'd0);
        chk("rst_data",  32'(bus.result_data_out),  32'd0);
        chk("rst_ovr",   32'(overrun),              32'd0);
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // T1 bypass
        send(1, 12'hABC, 0);
        idle(2);
        expect_pop("t1_bypass", 1, 16'hABC0);

        // mode above MAX_MODE is coerced to bypass
        send(0, 12'h321, 7);
        idle(2);
        expect_pop("coerce_mode", 0, 16'h3210);

        // T2 m=1 full scale
        for (int i = 0; i < 3; i++) send(0, 12'hFFF, 1);
        idle(2);
        chk("t2_no_early", 32'(got_data.size()), 32'd0);
        send(0, 12'hFFF, 1);
        idle(2);
        expect_pop("t2_fullscale", 0, 16'hFFF0);

        // T3 interleaved m=2
        for (int i = 0; i < 16; i++) begin
            send(0, 12'h100, 2);
            send(2, 12'h003, 2);
        end
        idle(2);
        expect_pop("t3_ch0", 0, 16'h1000);
        expect_pop("t3_ch2", 2, 16'h0030);

        // T4 m=4, mode request changes mid-window
        for (int i = 0; i < 255; i++) send(0, 12'h001, (i < 10) ? 4 : 1);
        idle(2);
        chk("t4_no_early", 32'(got_data.size()), 32'd0);
        send(0, 12'h001, 1);
        idle(2);
        expect_pop("t4_m4", 0, 16'h0010);
        chk("t4_single", 32'(got_data.size()), 32'd0);

        // T5 overrun while not ready
        bus.result_ready_in = 1'b0;
        send(0, 12'h123, 0);
        send(2, 12'h456, 0);
        chk("t5_held_data", 32'(bus.result_data_out), 32'h1230);
        chk("t5_held_ch",   32'(bus.result_ch_out),   32'd0);
        chk("t5_overrun",   32'(overrun),             32'd1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        chk("t5_clr_valid", 32'(bus.result_valid_out), 32'd0);
        chk("t5_clr_data",  32'(bus.result_data_out),  32'd0);
        chk("t5_clr_ovr",   32'(overrun),              32'd0);

        // T6 async reset mid-window, then a fresh window with out-of-range samples mixed in
        send(2, 12'h7FF, 0);
        for (int i = 0; i < 30; i++) send(1, 12'h0AB, 3);
        chk("t6_pre_valid", 32'(bus.result_valid_out), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(bus.result_valid_out), 32'd0);
        chk("t6_rst_data",  32'(bus.result_data_out),  32'd0);
        chk("t6_rst_ch",    32'(bus.result_ch_out),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.result_ready_in = 1'b1;
        for (int i = 0; i < 64; i++) begin
            send(1, 12'h0AB, 3);
            if (i % 8 == 0) send(3, 12'hFFF, 0);
        end
        idle(2);
        expect_pop("t6_fresh", 1, 16'h0AB0);
        chk("t6_no_extra", 32'(got_data.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
